// File: rtl/scene_pkg.sv
// Shared defaults and types for the scrolling scene address generator.
package scene_pkg;

  localparam int DEF_IMG_W       = 400;
  localparam int DEF_IMG_H       = 224;
  localparam int DEF_VIS_W       = 320;
  localparam int DEF_Y_OFS       = 8;
  localparam int DEF_SCROLL_STEP = 2;
  localparam int DEF_CAM_INIT    = 40;
  localparam int DEF_ADDR_W      = 17;

  // Rightmost legal camera offset for the default geometry.
  localparam int CAM_MAX = DEF_IMG_W - DEF_VIS_W;

  typedef enum logic {S_COLLECT, S_APPLY} cam_state_t;

endpackage

// File: rtl/scene_camera.sv
// Horizontal camera: collects scroll requests during a frame and applies
// one clamped step right after frame_start, so the offset never moves
// while visible pixels are being drawn.
module scene_camera
  import scene_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int VIS_W       = DEF_VIS_W,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP,
  parameter int CAM_INIT    = DEF_CAM_INIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       scroll_left,
  input  logic       scroll_right,
  output logic [8:0] camera_x,
  output logic       at_left_edge,
  output logic       at_right_edge
);

  localparam logic signed [9:0] STEP_S  = 10'(SCROLL_STEP);
  localparam logic signed [9:0] LIMIT_S = 10'(IMG_W - VIS_W);
  localparam logic        [8:0] LIMIT   = 9'(IMG_W - VIS_W);
  localparam logic        [8:0] INIT    = 9'(CAM_INIT);

  cam_state_t state;
  logic       pend_l;
  logic       pend_r;

  // One step left, saturating at zero; signed intermediate avoids wrap.
  function automatic logic [8:0] pan_left(input logic [8:0] cam);
    logic signed [9:0] t;
    t = $signed({1'b0, cam}) - STEP_S;
    return (t < 10'sd0) ? 9'd0 : t[8:0];
  endfunction

  // One step right, saturating at the last window position.
  function automatic logic [8:0] pan_right(input logic [8:0] cam);
    logic signed [9:0] t;
    t = $signed({1'b0, cam}) + STEP_S;
    return (t > LIMIT_S) ? LIMIT : t[8:0];
  endfunction

  // Request collection and once-per-frame camera update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_COLLECT;
      pend_l   <= 1'b0;
      pend_r   <= 1'b0;
      camera_x <= INIT;
    end else begin
      case (state)
        S_COLLECT: begin
          // Requests arriving together with frame_start belong to no frame.
          if (frame_start) begin
            state <= S_APPLY;
          end else begin
            pend_l <= pend_l | scroll_left;
            pend_r <= pend_r | scroll_right;
          end
        end
        S_APPLY: begin
          // Opposing requests cancel out.
          if (pend_l && !pend_r) begin
            camera_x <= pan_left(camera_x);
          end else if (pend_r && !pend_l) begin
            camera_x <= pan_right(camera_x);
          end
          pend_l <= 1'b0;
          pend_r <= 1'b0;
          state  <= S_COLLECT;
        end
      endcase
    end
  end

  assign at_left_edge  = (camera_x == 9'd0);
  assign at_right_edge = (camera_x == LIMIT);

endmodule

// File: rtl/scene_scroll_ctrl.sv
// Scene ROM address generator: maps pixel-doubled VGA coordinates onto a
// scene wider than the screen through a horizontal camera offset. The row
// base is accumulated line by line, so no multiplier is needed.
module scene_scroll_ctrl
  import scene_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int VIS_W       = DEF_VIS_W,
  parameter int Y_OFS       = DEF_Y_OFS,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP,
  parameter int CAM_INIT    = DEF_CAM_INIT,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              scroll_left,
  input  logic              scroll_right,
  output logic [ADDR_W-1:0] rom_address,
  output logic              scene_blank,
  output logic              in_scene,
  output logic [8:0]        camera_x,
  output logic              at_left_edge,
  output logic              at_right_edge
);

  localparam logic [9:0] X_END = 10'(VIS_W);
  localparam logic [9:0] Y_LO  = 10'(Y_OFS);
  localparam logic [9:0] Y_HI  = 10'(Y_OFS + IMG_H);

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic [9:0]        prev_y;
  logic [ADDR_W-1:0] row_base;
  logic              pix_valid;
  logic              row_step;

  scene_camera #(
    .IMG_W      (IMG_W),
    .VIS_W      (VIS_W),
    .SCROLL_STEP(SCROLL_STEP),
    .CAM_INIT   (CAM_INIT)
  ) u_camera (
    .clk          (vga_clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .scroll_left  (scroll_left),
    .scroll_right (scroll_right),
    .camera_x     (camera_x),
    .at_left_edge (at_left_edge),
    .at_right_edge(at_right_edge)
  );

  assign sx = draw_x >> 1;
  assign sy = draw_y >> 1;

  assign pix_valid = (sx < X_END) && (sy >= Y_LO) && (sy < Y_HI);

  // Advance once per doubled scene row, on the even line of the pair; the
  // first scene row keeps base zero.
  assign row_step = (draw_y != prev_y) && !draw_y[0] && (sy > Y_LO) && (sy < Y_HI);

  // Row base accumulator, restarted every frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      row_base <= '0;
      prev_y   <= '0;
    end else begin
      prev_y <= draw_y;
      if (frame_start) begin
        row_base <= '0;
      end else if (row_step) begin
        row_base <= row_base + ADDR_W'(IMG_W);
      end
    end
  end

  // Registered address with blank and in-scene flags kept in step.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      in_scene    <= 1'b0;
      scene_blank <= 1'b0;
    end else begin
      scene_blank <= blank;
      if (pix_valid) begin
        rom_address <= row_base + ADDR_W'(camera_x) + ADDR_W'(sx);
        in_scene    <= 1'b1;
      end else begin
        rom_address <= '0;
        in_scene    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scene_scroll_ctrl.sv
// Directed bench for scene_scroll_ctrl with a queued scoreboard: stimulus
// pushes expected responses tagged with the cycle they are due, and a
// monitor on the falling edge pops and compares them.
module tb_scene_scroll_ctrl;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  draw_x = 10'd700;
  logic [9:0]  draw_y = 10'd490;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        scroll_left = 1'b0;
  logic        scroll_right = 1'b0;
  logic [16:0] rom_address;
  logic        scene_blank;
  logic        in_scene;
  logic [8:0]  camera_x;
  logic        at_left_edge;
  logic        at_right_edge;

  typedef struct {
    int          cyc;
    bit          kind;
    logic [16:0] addr;
    logic        ins;
    logic        blk;
    logic [8:0]  cam;
    logic        le;
    logic        re;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   cam_m;

  scene_scroll_ctrl dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .draw_x       (draw_x),
    .draw_y       (draw_y),
    .blank        (blank),
    .frame_start  (frame_start),
    .scroll_left  (scroll_left),
    .scroll_right (scroll_right),
    .rom_address  (rom_address),
    .scene_blank  (scene_blank),
    .in_scene     (in_scene),
    .camera_x     (camera_x),
    .at_left_edge (at_left_edge),
    .at_right_edge(at_right_edge)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has come due.
  always @(negedge vga_clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: check reached at cycle %0d, required cycle %0d", e.tag, cyc, e.cyc);
      end else if (!e.kind) begin
        if (rom_address !== e.addr || in_scene !== e.ins || scene_blank !== e.blk) begin
          failures++;
          $display("FAIL %s: got addr=%0d in_scene=%0b scene_blank=%0b, required addr=%0d in_scene=%0b scene_blank=%0b",
                   e.tag, rom_address, in_scene, scene_blank, e.addr, e.ins, e.blk);
        end
      end else begin
        if (camera_x !== e.cam || at_left_edge !== e.le || at_right_edge !== e.re) begin
          failures++;
          $display("FAIL %s: got camera_x=%0d left=%0b right=%0b, required camera_x=%0d left=%0b right=%0b",
                   e.tag, camera_x, at_left_edge, at_right_edge, e.cam, e.le, e.re);
        end
      end
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic push_pix(input int a, input bit i, input bit b, input string t);
    exp_t e;
    e.cyc = cyc + 1; e.kind = 1'b0; e.addr = 17'(a); e.ins = i; e.blk = b;
    e.cam = '0; e.le = 1'b0; e.re = 1'b0; e.tag = t;
    q.push_back(e);
  endtask

  task automatic push_cam(input int c, input string t);
    exp_t e;
    e.cyc = cyc + 1; e.kind = 1'b1; e.addr = '0; e.ins = 1'b0; e.blk = 1'b0;
    e.cam = 9'(c); e.le = (c == 0); e.re = (c == 80); e.tag = t;
    q.push_back(e);
  endtask

  // Present one pixel and expect its registered response on the next edge.
  task automatic pix(input int x, input int y, input bit b, input int a, input bit i, input string t);
    draw_x = 10'(x); draw_y = 10'(y); blank = b;
    push_pix(a, i, b, t);
    tick();
  endtask

  // Move to a line with the beam in horizontal blanking.
  task automatic hline(input int y);
    draw_x = 10'd700; draw_y = 10'(y); blank = 1'b0;
    tick();
  endtask

  // One frame: requests for one clock, then frame_start, then the apply clock.
  task automatic frame(input bit l, input bit r, input int c, input string t);
    scroll_left = l; scroll_right = r; tick();
    scroll_left = 1'b0; scroll_right = 1'b0; tick();
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    push_cam(c, t);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1; blank = 1'b1;
    push_pix(0, 1'b0, 1'b0, "reset_pix");
    push_cam(40, "reset_cam");
    tick();
    tick();
    reset = 1'b0; blank = 1'b0;

    // First frame, no requests; first scene row at camera 40
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick(); tick();
    hline(16);
    pix(0, 16, 1'b1, 40, 1'b1, "t1_row0_x0");
    hline(18);
    pix(10, 18, 1'b1, 445, 1'b1, "t2_row1_x10");
    for (int y = 19; y <= 463; y++) hline(y);
    pix(0, 463, 1'b1, 89240, 1'b1, "t2_lastrow_x0");
    pix(636, 463, 1'b1, 89558, 1'b1, "t2_lastrow_x636");
    pix(640, 463, 1'b1, 0, 1'b0, "t3_sx320");
    pix(638, 463, 1'b0, 89559, 1'b1, "t3_blank_low");
    hline(464);
    pix(0, 464, 1'b1, 0, 1'b0, "t2_below_scene");
    hline(14);
    pix(0, 14, 1'b1, 0, 1'b0, "t3_above_scene");

    // Pan right until saturation
    cam_m = 40;
    for (int i = 0; i < 45; i++) begin
      cam_m = (cam_m + 2 > 80) ? 80 : cam_m + 2;
      frame(1'b0, 1'b1, cam_m, "t4_right");
    end
    // Pan left until saturation
    for (int i = 0; i < 45; i++) begin
      cam_m = (cam_m < 2) ? 0 : cam_m - 2;
      frame(1'b1, 1'b0, cam_m, "t4_left");
    end

    // Move to 20, then cancellation and dropped-request cases
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b1, 2 * (i + 1), "t5_setup");
    scroll_left = 1'b1; tick(); scroll_left = 1'b0; tick();
    scroll_right = 1'b1; tick(); scroll_right = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    push_cam(20, "t5_both_cancel"); tick();

    scroll_right = 1'b1; frame_start = 1'b1; tick();
    scroll_right = 1'b0; frame_start = 1'b0;
    push_cam(20, "t5_req_on_frame_start"); tick();

    frame_start = 1'b1; tick(); frame_start = 1'b0;
    scroll_right = 1'b1; push_cam(20, "t5_req_in_apply"); tick();
    scroll_right = 1'b0;
    frame(1'b0, 1'b0, 20, "t5_apply_req_dropped");

    repeat (3) tick();
    scroll_right = 1'b1; tick(); scroll_right = 1'b0;
    repeat (5) tick();
    frame_start = 1'b1; push_cam(20, "t5_pulse_not_early"); tick();
    frame_start = 1'b0; push_cam(22, "t5_pulse_applied"); tick();

    // Reach 60, leave a pending right request, then reset mid-frame
    for (int i = 0; i < 19; i++) frame(1'b0, 1'b1, 24 + 2 * i, "t6_setup");
    hline(16);
    scroll_right = 1'b1; tick(); scroll_right = 1'b0; tick();
    reset = 1'b1; frame_start = 1'b1; draw_x = 10'd0; draw_y = 10'd16; blank = 1'b1;
    push_pix(0, 1'b0, 1'b0, "t6_reset_pix");
    push_cam(40, "t6_reset_cam");
    tick();
    frame_start = 1'b0; tick();
    reset = 1'b0; blank = 1'b0; tick(); tick();
    push_cam(40, "t6_no_change_after_reset"); tick();
    frame(1'b0, 1'b0, 40, "t6_pending_cleared");

    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
